code_buffer_fifo: RTL and testbench

- Downstream consumer of the 16-bit LFSR pseudo-random generator's registered 4-bit code output.
- Captures codes on demand, either single samples or a burst fill, into a small FIFO.
- Presents buffered codes to the next stage (display/game logic) over a valid/ready handshake, so consumers can take random values at their own pace rather than tracking the free-running LFSR.

---
 rtl/code_pkg.sv | 15 +
 rtl/code_fifo_mem.sv | 28 ++
 rtl/code_buffer_fifo.sv | 123 ++++++++++++
 tb/tb_code_buffer_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/code_pkg.sv
// Shared definitions for the pseudo-random code path: code width, code type
// and the capture FSM state encoding.
package code_pkg;

    // Width of one code as produced by the LFSR generator's code output.
    localparam int CODE_W = 4;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/code_fifo_mem.sv
// Code storage for the buffer FIFO: DEPTH x CODE_W register array with one
// synchronous write port and one asynchronous read port. Contents are never
// cleared; validity is tracked by the owner's count.
module code_fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int CODE_W = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] mem_q [DEPTH];

    // Write one code per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/code_buffer_fifo.sv
// Buffers codes from the free-running pseudo-random generator so that a
// downstream consumer can take them at its own pace. Codes are captured one
// per cycle while sample is high, or as a burst (FILL state) until full, and
// presented show-ahead over a valid/ready handshake.
module code_buffer_fifo
    import code_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CODE_W = code_pkg::CODE_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              preset,
    input  logic [CODE_W-1:0] code_in,
    input  logic              sample,
    input  logic              fill,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fill_state_t       state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;
    logic [CODE_W-1:0] rd_data;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign out_valid = !empty;
    assign busy      = (state_q == FILL);
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A full FIFO rejects every push, even when a pop frees a slot this cycle.
    assign push = !full && (((state_q == IDLE) && sample) || (state_q == FILL));
    assign pop  = out_valid && out_ready;

    // Storage contents survive reset, so gate the head with out_valid to show 0.
    assign out_code = out_valid ? rd_data : '0;

    code_fifo_mem #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !preset),
        .waddr (wr_ptr_q),
        .wdata (code_in),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A capture request (single sample or burst start) hitting a full FIFO.
        if ((state_q == IDLE) && full && (sample || fill)) begin
            overflow_d = 1'b1;
        end
    end

    // Capture FSM: leave FILL on the push that makes the FIFO full, or at once if full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fill && !full) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (full || (count_d == FULL_CNT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons all buffered contents.
    always_ff @(posedge clk) begin
        if (preset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_code_buffer_fifo.sv
// Directed self-checking bench for code_buffer_fifo (DEPTH=8, CODE_W=4).
module tb_code_buffer_fifo;

    logic       clk = 1'b0;
    logic       preset;
    logic [3:0] code_in;
    logic       sample;
    logic       fill;
    logic [3:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    code_buffer_fifo #(.DEPTH(8), .CODE_W(4)) dut (
        .clk       (clk),
        .preset    (preset),
        .code_in   (code_in),
        .sample    (sample),
        .fill      (fill),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are stable across the edge, outputs read 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_empty(input string tag);
        chk({tag, " count"},     count,     0);
        chk({tag, " empty"},     empty,     1);
        chk({tag, " full"},      full,      0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_code"},  out_code,  0);
        chk({tag, " busy"},      busy,      0);
        chk({tag, " overflow"},  overflow,  0);
    endtask

    // Pulse fill, then drive code_in = (base + i) & 15 for i = 1..n pushes.
    task automatic burst(input int base, input int n, input string tag);
        fill = 1'b1;
        step();
        fill = 1'b0;
        chk({tag, " busy after fill"}, busy, 1);
        for (int i = 1; i <= n; i++) begin
            code_in = 4'((base + i) & 15);
            step();
            chk($sformatf("%s count push%0d", tag, i), count, i);
            chk($sformatf("%s busy push%0d", tag, i), busy, (i < 8) ? 1 : 0);
        end
    endtask

    // Pop n entries expecting heads (base + first .. base + first + n - 1) & 15.
    task automatic drain(input int base, input int first, input int n, input string tag);
        out_ready = 1'b1;
        for (int i = first; i < first + n; i++) begin
            chk($sformatf("%s head%0d", tag, i), out_code, (base + i) & 15);
            step();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        preset    = 1'b1;
        code_in   = 4'h0;
        sample    = 1'b0;
        fill      = 1'b0;
        out_ready = 1'b0;
        #2;

        // Reset held two cycles with other inputs toggling.
        for (int i = 0; i < 2; i++) begin
            sample    = ~sample;
            fill      = (i == 0);
            out_ready = ~out_ready;
            code_in   = 4'(i + 3);
            step();
        end
        chk_idle_empty("reset");
        preset = 1'b0; sample = 1'b0; fill = 1'b0; out_ready = 1'b0;
        step();
        chk_idle_empty("post-reset");
        $display("txn reset: count=%0d empty=%0d", count, empty);

        // Single sample, then pop it.
        code_in = 4'hA; sample = 1'b1;
        step();
        sample = 1'b0;
        chk("single valid", out_valid, 1);
        chk("single code",  out_code,  10);
        chk("single count", count,     1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single pop empty", empty, 1);
        chk("single pop count", count, 0);
        $display("txn single: pushed A, popped, empty=%0d", empty);

        // Burst fill 1..8, then drain in order.
        burst(0, 8, "fill1");
        chk("fill1 full", full, 1);
        drain(0, 1, 8, "drain1");
        chk("drain1 empty", empty, 1);
        $display("txn fill/drain 1..8: empty=%0d", empty);

        // Full FIFO, sample with simultaneous pop: push rejected, overflow set.
        burst(8, 8, "fill2");
        code_in = 4'h5; sample = 1'b1; out_ready = 1'b1;
        step();
        sample = 1'b0; out_ready = 1'b0;
        chk("ovf count", count, 7);
        chk("ovf flag", overflow, 1);
        drain(8, 2, 7, "drain2");
        chk("drain2 empty", empty, 1);
        chk("ovf sticky", overflow, 1);
        $display("txn overflow: flag=%0d count=%0d", overflow, count);

        // Steady state at count=3 across pointer wrap.
        sample = 1'b1;
        for (int i = 0; i < 3; i++) begin
            code_in = 4'(i);
            step();
        end
        chk("prefill count", count, 3);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            code_in = 4'((3 + k) & 15);
            chk($sformatf("stream head%0d", k), out_code, k & 15);
            step();
            chk($sformatf("stream count%0d", k), count, 3);
        end
        sample = 1'b0;
        drain(0, 20, 3, "stream tail");
        chk("stream empty", empty, 1);
        $display("txn stream: 20 push+pop at count 3, final count=%0d", count);

        // Reset in the middle of a burst at count=5.
        fill = 1'b1;
        step();
        fill = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            code_in = 4'(i);
            step();
        end
        chk("midfill count", count, 5);
        chk("midfill busy",  busy,  1);
        preset = 1'b1;
        step();
        preset = 1'b0;
        chk_idle_empty("midfill reset");
        burst(6, 8, "fill3");
        chk("fill3 full", full, 1);
        drain(6, 1, 8, "drain3");
        chk("drain3 empty", empty, 1);
        $display("txn reset mid-fill then fresh fill: empty=%0d", empty);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
